// File: rtl/execution_matcher_pkg.sv
// Shared constants and event/order record types for the execution matcher.
// The module parameters default to the DEF_* values defined here.
package hft_exec_pkg;

  localparam int DEF_NUM_STOCKS      = 4;
  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_ORDER_REF_WIDTH = 64;
  localparam int DEF_FIFO_DEPTH      = 8;
  localparam int DEF_SIDW            = $clog2(DEF_NUM_STOCKS);

  localparam logic SIDE_BID = 1'b0;
  localparam logic SIDE_ASK = 1'b1;

  typedef struct packed {
    logic [DEF_SIDW-1:0]       stock_id;
    logic                      side;
    logic [DEF_DATA_WIDTH-1:0] quantity;
  } exec_event_t;

  typedef struct packed {
    logic                           valid;
    logic [DEF_ORDER_REF_WIDTH-1:0] order_ref;
    logic [DEF_DATA_WIDTH-1:0]      remaining;
  } order_entry_t;

endpackage

// File: rtl/execution_matcher_if.sv
// Quote, execute, inventory-handshake and fill signals of the execution matcher.
interface execution_matcher_if
  import hft_exec_pkg::*;
#(
  parameter int NUM_STOCKS      = DEF_NUM_STOCKS,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int ORDER_REF_WIDTH = DEF_ORDER_REF_WIDTH
);
  localparam int SIDW = $clog2(NUM_STOCKS);

  logic                       i_quote_valid;
  logic [SIDW-1:0]            i_quote_stock_id;
  logic                       i_quote_side;
  logic [ORDER_REF_WIDTH-1:0] i_quote_order_ref;
  logic [DATA_WIDTH-1:0]      i_quote_quantity;
  logic                       i_exec_valid;
  logic [ORDER_REF_WIDTH-1:0] i_exec_order_ref;
  logic [DATA_WIDTH-1:0]      i_exec_quantity;
  logic                       i_inventory_ready;
  logic [SIDW-1:0]            o_stock_id;
  logic                       o_execute_order;
  logic                       o_execute_order_side;
  logic [DATA_WIDTH-1:0]      o_execute_order_quantity;
  logic                       o_unmatched;
  logic                       o_overflow;

  modport master (
    output i_quote_valid, i_quote_stock_id, i_quote_side, i_quote_order_ref, i_quote_quantity,
    output i_exec_valid, i_exec_order_ref, i_exec_quantity, i_inventory_ready,
    input  o_stock_id, o_execute_order, o_execute_order_side, o_execute_order_quantity,
    input  o_unmatched, o_overflow
  );

  modport slave (
    input  i_quote_valid, i_quote_stock_id, i_quote_side, i_quote_order_ref, i_quote_quantity,
    input  i_exec_valid, i_exec_order_ref, i_exec_quantity, i_inventory_ready,
    output o_stock_id, o_execute_order, o_execute_order_side, o_execute_order_quantity,
    output o_unmatched, o_overflow
  );

endinterface

// File: rtl/execution_matcher_fifo.sv
// Synchronous FIFO of fill events; a push into a full FIFO is accepted only
// when a pop frees a slot on the same edge.
module exec_event_fifo
  import hft_exec_pkg::*;
#(
  parameter int  DEPTH   = DEF_FIFO_DEPTH,
  parameter type event_t = exec_event_t
) (
  input  logic   clk,
  input  logic   srst,
  input  logic   push,
  input  event_t push_data,
  input  logic   pop,
  output event_t head,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);

  event_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/execution_matcher.sv
// Matches exchange executes against our live quotes (one per stock/side) and
// queues the resulting fills for the inventory block.
module execution_matcher
  import hft_exec_pkg::*;
#(
  parameter int NUM_STOCKS      = DEF_NUM_STOCKS,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int ORDER_REF_WIDTH = DEF_ORDER_REF_WIDTH,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
  input logic          i_clk,
  input logic          i_reset,
  execution_matcher_if.slave bus
);
  localparam int SIDW        = $clog2(NUM_STOCKS);
  localparam int IDXW        = SIDW + 1;
  localparam int NUM_ENTRIES = 2 * NUM_STOCKS;

  typedef struct packed {
    logic [SIDW-1:0]       stock_id;
    logic                  side;
    logic [DATA_WIDTH-1:0] quantity;
  } event_t;

  typedef struct packed {
    logic                       valid;
    logic [ORDER_REF_WIDTH-1:0] order_ref;
    logic [DATA_WIDTH-1:0]      remaining;
  } entry_t;

  entry_t                     table_reg [NUM_ENTRIES];
  logic                       s1_valid_reg;
  logic [ORDER_REF_WIDTH-1:0] s1_ref_reg;
  logic [DATA_WIDTH-1:0]      s1_qty_reg;

  logic [NUM_ENTRIES-1:0]     hit_vec;
  logic                       match_any;
  logic [IDXW-1:0]            match_idx;
  logic [DATA_WIDTH-1:0]      match_rem;
  logic [DATA_WIDTH-1:0]      fill_qty;
  logic                       s2_active;
  logic                       push;
  event_t                     push_event;
  logic [IDXW-1:0]            quote_idx;

  event_t                     fifo_head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       pop;

  event_t                     out_event_reg;
  logic                       out_valid_reg;
  logic                       unmatched_reg;
  logic                       overflow_reg;

  // S1: register the execute message
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= bus.i_exec_valid;
    end
    s1_ref_reg <= bus.i_exec_order_ref;
    s1_qty_reg <= bus.i_exec_quantity;
  end

  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_cmp
      assign hit_vec[gi] = table_reg[gi].valid && (table_reg[gi].order_ref == s1_ref_reg);
    end
  endgenerate

  // Lowest index wins when the same ref is live in several entries
  always_comb begin
    match_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        match_idx = IDXW'(i);
      end
    end
  end

  assign match_any  = |hit_vec;
  assign match_rem  = table_reg[match_idx].remaining;
  assign fill_qty   = (s1_qty_reg < match_rem) ? s1_qty_reg : match_rem;
  assign s2_active  = s1_valid_reg && (s1_qty_reg != '0);
  assign push       = s2_active && match_any;
  assign quote_idx  = {bus.i_quote_stock_id, bus.i_quote_side};

  assign push_event.stock_id = match_idx[IDXW-1:1];
  assign push_event.side     = match_idx[0] ? SIDE_ASK : SIDE_BID;
  assign push_event.quantity = fill_qty;

  // The quote write is applied last so it overrides a same-edge fill update
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        table_reg[i].valid <= 1'b0;
      end
    end else begin
      if (push) begin
        table_reg[match_idx].remaining <= match_rem - fill_qty;
        table_reg[match_idx].valid     <= (match_rem != fill_qty);
      end
      if (bus.i_quote_valid) begin
        table_reg[quote_idx] <= '{valid:     (bus.i_quote_quantity != '0),
                                  order_ref: bus.i_quote_order_ref,
                                  remaining: bus.i_quote_quantity};
      end
    end
  end

  assign pop = !fifo_empty && bus.i_inventory_ready;

  exec_event_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .event_t (event_t)
  ) u_fifo (
    .clk       (i_clk),
    .srst      (i_reset),
    .push      (push),
    .push_data (push_event),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_valid_reg <= 1'b0;
      out_event_reg <= '0;
      unmatched_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      out_valid_reg <= pop;
      if (pop) begin
        out_event_reg <= fifo_head;
      end
      unmatched_reg <= s2_active && !match_any;
      if (push && fifo_full && !pop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign bus.o_execute_order          = out_valid_reg;
  assign bus.o_stock_id               = out_event_reg.stock_id;
  assign bus.o_execute_order_side     = out_event_reg.side;
  assign bus.o_execute_order_quantity = out_event_reg.quantity;
  assign bus.o_unmatched              = unmatched_reg;
  assign bus.o_overflow               = overflow_reg;

endmodule
